// File: rtl/cpu_pkg.sv
// Shared writeback definitions: default widths, the PC register index and source tags.
package cpu_pkg;

   localparam int unsigned DW_DEF = 32;
   localparam int unsigned AW_DEF = 4;
   localparam logic [3:0]  REG_PC = 4'hF;

   typedef enum logic {
      WB_ALU = 1'b0,
      WB_MEM = 1'b1
   } wb_src_e;

endpackage

// File: rtl/wb_holding_slot.sv
// One-entry writeback holding buffer; a load on the same edge as a drain refills it.
module wb_holding_slot #(
   parameter int unsigned AW = 4,
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_i,
   input  logic          drain_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] data_i,
   output logic          full_o,
   output logic [AW-1:0] addr_o,
   output logic [DW-1:0] data_o
);

   logic          full_q, full_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;

   always_comb begin
      full_d = full_q;
      addr_d = addr_q;
      data_d = data_q;
      if (drain_i) begin
         full_d = 1'b0;
      end
      if (load_i) begin
         full_d = 1'b1;
         addr_d = addr_i;
         data_d = data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end

   assign full_o = full_q;
   assign addr_o = addr_q;
   assign data_o = data_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates ALU and load writeback onto the single register-file write port,
// diverting R15 writes to the PC write port.
module rf_write_arbiter
   import cpu_pkg::*;
#(
   parameter int unsigned DW         = DW_DEF,
   parameter int unsigned AW         = AW_DEF,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          alu_valid,
   output logic          alu_ready,
   input  logic [AW-1:0] alu_addr,
   input  logic [DW-1:0] alu_data,
   input  logic          mem_valid,
   output logic          mem_ready,
   input  logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_data,
   output logic          we3,
   output logic [AW-1:0] wa3,
   output logic [DW-1:0] wd3,
   output logic          pc_we,
   output logic [DW-1:0] pc_wd,
   output logic [15:0]   rf_busy
);

   localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   logic          alu_full, mem_full;
   logic [AW-1:0] alu_addr_h, mem_addr_h;
   logic [DW-1:0] alu_data_h, mem_data_h;
   logic          alu_grant, mem_grant, any_grant;
   logic          alu_acc, mem_acc;
   wb_src_e       win_src;
   logic [AW-1:0] win_addr;
   logic [DW-1:0] win_data;

   // age_q set means the held mem entry is older than the held alu entry
   logic          age_q, age_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          we3_q, we3_d, pc_we_q, pc_we_d;
   logic [AW-1:0] wa3_q, wa3_d;
   logic [DW-1:0] wd3_q, wd3_d, pc_wd_q, pc_wd_d;

   wb_holding_slot #(.AW(AW), .DW(DW)) u_alu_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (alu_acc),
      .drain_i (alu_grant),
      .addr_i  (alu_addr),
      .data_i  (alu_data),
      .full_o  (alu_full),
      .addr_o  (alu_addr_h),
      .data_o  (alu_data_h)
   );

   wb_holding_slot #(.AW(AW), .DW(DW)) u_mem_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (mem_acc),
      .drain_i (mem_grant),
      .addr_i  (mem_addr),
      .data_i  (mem_data),
      .full_o  (mem_full),
      .addr_o  (mem_addr_h),
      .data_o  (mem_data_h)
   );

   always_comb begin
      win_src = WB_MEM;
      if (alu_full && mem_full) begin
         if (alu_addr_h == mem_addr_h) begin
            win_src = age_q ? WB_MEM : WB_ALU;
         end else if (starve_q == STARVE_LIM) begin
            win_src = WB_ALU;
         end
      end else if (alu_full) begin
         win_src = WB_ALU;
      end
   end

   assign any_grant = alu_full | mem_full;
   assign alu_grant = any_grant & (win_src == WB_ALU);
   assign mem_grant = any_grant & (win_src == WB_MEM);
   assign win_addr  = (win_src == WB_ALU) ? alu_addr_h : mem_addr_h;
   assign win_data  = (win_src == WB_ALU) ? alu_data_h : mem_data_h;

   assign alu_ready = rst_n & (~alu_full | alu_grant);
   assign mem_ready = rst_n & (~mem_full | mem_grant);
   assign alu_acc   = alu_valid & alu_ready;
   assign mem_acc   = mem_valid & mem_ready;

   // An alu acceptance always leaves mem as the older (or absent) entry, also on a same-edge tie.
   always_comb begin
      age_d = age_q;
      if (alu_acc) begin
         age_d = 1'b1;
      end else if (mem_acc) begin
         age_d = 1'b0;
      end
   end

   always_comb begin
      starve_d = '0;
      if (alu_full && !alu_grant) begin
         starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + SW'(1);
      end
   end

   always_comb begin
      we3_d   = 1'b0;
      pc_we_d = 1'b0;
      wa3_d   = wa3_q;
      wd3_d   = wd3_q;
      pc_wd_d = pc_wd_q;
      if (any_grant) begin
         if (win_addr == AW'(REG_PC)) begin
            pc_we_d = 1'b1;
            pc_wd_d = win_data;
         end else begin
            we3_d = 1'b1;
            wa3_d = win_addr;
            wd3_d = win_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         age_q    <= 1'b0;
         starve_q <= '0;
         we3_q    <= 1'b0;
         wa3_q    <= '0;
         wd3_q    <= '0;
         pc_we_q  <= 1'b0;
         pc_wd_q  <= '0;
      end else begin
         age_q    <= age_d;
         starve_q <= starve_d;
         we3_q    <= we3_d;
         wa3_q    <= wa3_d;
         wd3_q    <= wd3_d;
         pc_we_q  <= pc_we_d;
         pc_wd_q  <= pc_wd_d;
      end
   end

   always_comb begin
      rf_busy = '0;
      if (alu_full) begin
         rf_busy[alu_addr_h] = 1'b1;
      end
      if (mem_full) begin
         rf_busy[mem_addr_h] = 1'b1;
      end
      if (we3_q) begin
         rf_busy[wa3_q] = 1'b1;
      end
      if (pc_we_q) begin
         rf_busy[15] = 1'b1;
      end
   end

   assign we3   = we3_q;
   assign wa3   = wa3_q;
   assign wd3   = wd3_q;
   assign pc_we = pc_we_q;
   assign pc_wd = pc_wd_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: transaction-level reference model feeds an
// expected-write queue that a negedge monitor drains against the write ports.
module tb_rf_write_arbiter;

   localparam int SMAX = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        alu_valid = 1'b0, mem_valid = 1'b0;
   logic [3:0]  alu_addr = '0, mem_addr = '0;
   logic [31:0] alu_data = '0, mem_data = '0;
   logic        alu_ready, mem_ready, we3, pc_we;
   logic [3:0]  wa3;
   logic [31:0] wd3, pc_wd;
   logic [15:0] rf_busy;

   rf_write_arbiter #(.DW(32), .AW(4), .STARVE_MAX(SMAX)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_addr  (alu_addr),
      .alu_data  (alu_data),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .we3       (we3),
      .wa3       (wa3),
      .wd3       (wd3),
      .pc_we     (pc_we),
      .pc_wd     (pc_wd),
      .rf_busy   (rf_busy)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct { bit v; logic [3:0] addr; logic [31:0] data; } req_t;
   typedef struct { logic [3:0] addr; logic [31:0] data; int unsigned tk; } ent_t;
   typedef struct { int unsigned cyc; logic [3:0] addr; logic [31:0] data; } exp_t;

   req_t areq[$], mreq[$];
   ent_t aq[$], mq[$];
   exp_t expq[$];
   int unsigned tick = 0;
   int starve = 0;
   bit last_we = 0, last_pc = 0;
   logic [3:0] last_wa = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // 0 = nothing held, 1 = alu wins, 2 = mem wins; tickets order entries by arrival
   function automatic int winner();
      if (aq.size() == 0 && mq.size() == 0) return 0;
      if (mq.size() == 0) return 1;
      if (aq.size() == 0) return 2;
      if (aq[0].addr == mq[0].addr) return (aq[0].tk < mq[0].tk) ? 1 : 2;
      return (starve >= SMAX) ? 1 : 2;
   endfunction

   task automatic model_edge(output bit acc_a, output bit acc_m);
      int   w;
      bit   a_full;
      ent_t e;
      w      = winner();
      a_full = (aq.size() != 0);
      acc_a  = alu_valid && (aq.size() == 0 || w == 1);
      acc_m  = mem_valid && (mq.size() == 0 || w == 2);
      last_we = 0;
      last_pc = 0;
      if (w != 0) begin
         e = (w == 1) ? aq.pop_front() : mq.pop_front();
         expq.push_back('{cyc, e.addr, e.data});
         if (e.addr == 4'hF) last_pc = 1;
         else begin
            last_we = 1;
            last_wa = e.addr;
         end
      end
      starve = (a_full && w != 1) ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
      if (acc_m) mq.push_back('{mem_addr, mem_data, tick++});
      if (acc_a) aq.push_back('{alu_addr, alu_data, tick++});
   endtask

   task automatic step();
      bit          acc_a, acc_m;
      req_t        r;
      logic [15:0] b;
      @(posedge clk);
      #2;
      model_edge(acc_a, acc_m);
      if (!(alu_valid && !acc_a)) begin
         if (areq.size() > 0) begin
            r = areq.pop_front();
            alu_valid = r.v; alu_addr = r.addr; alu_data = r.data;
         end else alu_valid = 1'b0;
      end
      if (!(mem_valid && !acc_m)) begin
         if (mreq.size() > 0) begin
            r = mreq.pop_front();
            mem_valid = r.v; mem_addr = r.addr; mem_data = r.data;
         end else mem_valid = 1'b0;
      end
      #1;
      chk("alu_ready", alu_ready, (aq.size() == 0 || winner() == 1));
      chk("mem_ready", mem_ready, (mq.size() == 0 || winner() == 2));
      b = '0;
      foreach (aq[i]) b[aq[i].addr] = 1'b1;
      foreach (mq[i]) b[mq[i].addr] = 1'b1;
      if (last_we) b[last_wa] = 1'b1;
      if (last_pc) b[15] = 1'b1;
      chk("rf_busy", rf_busy, b);
   endtask

   task automatic drain();
      for (int i = 0; i < 60; i++) begin
         if (aq.size() == 0 && mq.size() == 0 && areq.size() == 0 && mreq.size() == 0 &&
             expq.size() == 0 && !alu_valid && !mem_valid) return;
         step();
      end
      chk("drain_timeout", 0, 1);
   endtask

   task automatic reset_with_full_slots();
      areq.delete();
      mreq.delete();
      drain();
      areq.push_back('{1'b1, 4'd2, 32'h1111_2222});
      mreq.push_back('{1'b1, 4'd4, 32'h4444_5555});
      step();
      step();
      rst_n = 1'b0;
      alu_valid = 1'b0;
      mem_valid = 1'b0;
      #1;
      chk("rst_we3", we3, 0);
      chk("rst_pc_we", pc_we, 0);
      chk("rst_rf_busy", rf_busy, 0);
      chk("rst_alu_ready", alu_ready, 0);
      chk("rst_mem_ready", mem_ready, 0);
      aq.delete(); mq.delete(); expq.delete();
      starve = 0; last_we = 0; last_pc = 0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      chk("rel_alu_ready", alu_ready, 1);
      chk("rel_mem_ready", mem_ready, 1);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n) begin
         if (we3 || pc_we) begin
            if (expq.size() == 0) chk("unexpected_write", {we3, pc_we}, 0);
            else begin
               e = expq.pop_front();
               chk("write_cycle", cyc, e.cyc);
               if (e.addr == 4'hF) begin
                  chk("pc_we", pc_we, 1);
                  chk("we3_on_pc", we3, 0);
                  chk("pc_wd", pc_wd, e.data);
               end else begin
                  chk("we3", we3, 1);
                  chk("pc_we_on_rf", pc_we, 0);
                  chk("wa3", wa3, e.addr);
                  chk("wd3", wd3, e.data);
               end
            end
         end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
            e = expq.pop_front();
            chk("missing_write", 0, 1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #2;
      chk("init_we3", we3, 0);
      chk("init_wa3", wa3, 0);
      chk("init_wd3", wd3, 0);
      chk("init_pc_we", pc_we, 0);
      chk("init_pc_wd", pc_wd, 0);
      chk("init_alu_ready", alu_ready, 0);
      chk("init_mem_ready", mem_ready, 0);
      chk("init_rf_busy", rf_busy, 0);
      rst_n = 1'b1;
      #1;
      chk("init_rel_alu_ready", alu_ready, 1);
      chk("init_rel_mem_ready", mem_ready, 1);

      // single alu write
      areq.push_back('{1'b1, 4'd3, 32'hDEAD_BEEF});
      drain();

      // sustained contention on distinct addresses
      for (int i = 0; i < 12; i++) begin
         areq.push_back('{1'b1, 4'(i % 7), $urandom});
         mreq.push_back('{1'b1, 4'(8 + i % 7), $urandom});
      end
      drain();

      // same address, same edge, then alu first
      mreq.push_back('{1'b1, 4'd5, 32'd1});
      areq.push_back('{1'b1, 4'd5, 32'd2});
      drain();
      areq.push_back('{1'b1, 4'd5, 32'd2});
      mreq.push_back('{1'b0, 4'd0, 32'd0});
      mreq.push_back('{1'b1, 4'd5, 32'd1});
      drain();

      // PC destination
      areq.push_back('{1'b1, 4'hF, 32'h100});
      drain();
      mreq.push_back('{1'b1, 4'hF, 32'h200});
      areq.push_back('{1'b1, 4'hF, 32'h300});
      drain();

      reset_with_full_slots();

      for (int i = 0; i < 3000; i++) begin
         if (areq.size() < 2)
            areq.push_back('{($urandom_range(0, 99) < 65), 4'($urandom_range(0, 15)), $urandom});
         if (mreq.size() < 2)
            mreq.push_back('{($urandom_range(0, 99) < 65), 4'($urandom_range(0, 15)), $urandom});
         step();
         if (i == 1500) reset_with_full_slots();
      end
      areq.delete();
      mreq.delete();
      drain();
      chk("scoreboard_empty", expq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
